micros_alarm_scheduler: RTL

- Shares one free-running 32-bit microsecond timebase among NUM_SLOTS alarm requesters.
- Each slot is armed with a delay and fires once (one-shot) or repeatedly (periodic); expiry is reported on a valid/ready event port.
- A single shared wrap-safe comparator is time-multiplexed over the slots by a round-robin scan FSM.
- Sits beside the microsecond timer in the PPM receive path, e.g. for frame-gap timeouts and failsafe watchdogs.

---
 rtl/micros_alarm_pkg.sv | 13 +
 rtl/micros_deadline_cmp.sv | 18 +
 rtl/micros_alarm_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/micros_alarm_pkg.sv
// Shared types for the microsecond alarm scheduler: timebase width, scan FSM states, time value.
package micros_alarm_pkg;

    localparam int DEF_TIME_W = 32;

    typedef enum logic {
        SCAN = 1'b0,
        FIRE = 1'b1
    } sched_state_t;

    typedef logic [DEF_TIME_W-1:0] time_t;

endpackage

// File: rtl/micros_deadline_cmp.sv
// Wrap-safe deadline compare: a slot is due once (micros - deadline) is non-negative as a signed value.
module micros_deadline_cmp
    import micros_alarm_pkg::*;
#(
    parameter int TIME_W = DEF_TIME_W
) (
    input  logic [TIME_W-1:0] micros_i,
    input  logic [TIME_W-1:0] deadline_i,
    input  logic              armed_i,
    output logic              expired_o
);

    logic [TIME_W-1:0] diff;

    assign diff      = micros_i - deadline_i;
    assign expired_o = armed_i && !diff[TIME_W-1];

endmodule

// File: rtl/micros_alarm_scheduler.sv
// Round-robin alarm scheduler sharing one deadline comparator over NUM_SLOTS one-shot/periodic slots.
// Optional saturating periodic-overrun counter under `MICROS_ALARM_OVERRUN_CNT_EN.
module micros_alarm_scheduler
    import micros_alarm_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int TIME_W    = DEF_TIME_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TIME_W-1:0]    micros,
    input  logic                 arm_valid,
    output logic                 arm_ready,
    input  logic [SLOT_W-1:0]    arm_slot,
    input  logic [TIME_W-1:0]    arm_delay,
    input  logic                 arm_periodic,
    input  logic                 cancel_valid,
    input  logic [SLOT_W-1:0]    cancel_slot,
    output logic                 fire_valid,
    output logic [SLOT_W-1:0]    fire_slot,
    input  logic                 fire_ready,
    output logic [NUM_SLOTS-1:0] armed
`ifdef MICROS_ALARM_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_cnt,
    input  logic                 overrun_clr
`endif
);

    // Handshakes: arm transfers on arm_valid && arm_ready, fire on fire_valid && fire_ready;
    // valid may not depend on ready, and fire_slot stays stable while fire_valid waits.

    sched_state_t         state_q, state_d;
    logic [SLOT_W-1:0]    scan_ptr_q, scan_ptr_d;
    logic [SLOT_W-1:0]    fire_slot_q, fire_slot_d;
    logic [NUM_SLOTS-1:0] armed_q, armed_d;
    logic [NUM_SLOTS-1:0] periodic_q, periodic_d;
    logic [TIME_W-1:0]    deadline_q [NUM_SLOTS];
    logic [TIME_W-1:0]    deadline_d [NUM_SLOTS];
    logic [TIME_W-1:0]    period_q   [NUM_SLOTS];
    logic [TIME_W-1:0]    period_d   [NUM_SLOTS];

    logic [TIME_W-1:0]    reload_deadline;
    logic [TIME_W-1:0]    cmp_deadline;
    logic                 cmp_armed;
    logic                 cmp_expired;
    logic                 cancel_hit_scan;
    logic                 cancel_hit_fire;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] p);
        if (p == SLOT_W'(NUM_SLOTS - 1)) return '0;
        return p + 1'b1;
    endfunction

    assign reload_deadline = deadline_q[fire_slot_q] + period_q[fire_slot_q];
    assign cancel_hit_scan = cancel_valid && (cancel_slot == scan_ptr_q);
    assign cancel_hit_fire = cancel_valid && (cancel_slot == fire_slot_q);

    // In FIRE the comparator is borrowed to ask whether the reloaded deadline is already due.
    always_comb begin
        cmp_deadline = deadline_q[scan_ptr_q];
        cmp_armed    = armed_q[scan_ptr_q];
        if (state_q == FIRE) begin
            cmp_deadline = reload_deadline;
            cmp_armed    = 1'b1;
        end
    end

    micros_deadline_cmp #(.TIME_W(TIME_W)) u_cmp (
        .micros_i   (micros),
        .deadline_i (cmp_deadline),
        .armed_i    (cmp_armed),
        .expired_o  (cmp_expired)
    );

    always_comb begin
        state_d     = state_q;
        scan_ptr_d  = scan_ptr_q;
        fire_slot_d = fire_slot_q;
        armed_d     = armed_q;
        periodic_d  = periodic_q;
        deadline_d  = deadline_q;
        period_d    = period_q;

        case (state_q)
            SCAN: begin
                if (cmp_expired && !cancel_hit_scan) begin
                    fire_slot_d = scan_ptr_q;
                    state_d     = FIRE;
                end else begin
                    scan_ptr_d = next_slot(scan_ptr_q);
                end
            end
            FIRE: begin
                if (cancel_hit_fire) begin
                    state_d    = SCAN;
                    scan_ptr_d = next_slot(fire_slot_q);
                end else if (fire_ready) begin
                    if (periodic_q[fire_slot_q]) deadline_d[fire_slot_q] = reload_deadline;
                    else                         armed_d[fire_slot_q]    = 1'b0;
                    state_d    = SCAN;
                    scan_ptr_d = next_slot(fire_slot_q);
                end
            end
            default: state_d = SCAN;
        endcase

        if (arm_valid && arm_ready) begin
            deadline_d[arm_slot] = micros + arm_delay;
            period_d[arm_slot]   = arm_delay;
            periodic_d[arm_slot] = arm_periodic;
            armed_d[arm_slot]    = 1'b1;
        end

        // Applied last so a same-cycle cancel overrides an arm of the same slot.
        if (cancel_valid) armed_d[cancel_slot] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            scan_ptr_q  <= '0;
            fire_slot_q <= '0;
            armed_q     <= '0;
            periodic_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                deadline_q[i] <= '0;
                period_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            scan_ptr_q  <= scan_ptr_d;
            fire_slot_q <= fire_slot_d;
            armed_q     <= armed_d;
            periodic_q  <= periodic_d;
            deadline_q  <= deadline_d;
            period_q    <= period_d;
        end
    end

    assign arm_ready  = (state_q == SCAN);
    assign fire_valid = (state_q == FIRE);
    assign fire_slot  = fire_slot_q;
    assign armed      = armed_q;

`ifdef MICROS_ALARM_OVERRUN_CNT_EN
    logic       overrun_inc;
    logic [7:0] overrun_cnt_q;

    assign overrun_inc = (state_q == FIRE) && fire_ready && !cancel_hit_fire
                         && periodic_q[fire_slot_q] && cmp_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt_q <= '0;
        end else if (overrun_inc) begin
            if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end else if (overrun_clr) begin
            overrun_cnt_q <= '0;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

endmodule
